// File: rtl/move_select_decoder.sv
// Registered move decoder: takes a move request over valid/ready, range- and occupancy-checks it,
// and then issues a one-hot cell write-enable tagged with the moving player.
module move_select_decoder #(
  parameter int N_CELLS = 9,
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               move_valid,
  input  logic [SEL_W-1:0]   move_sel,
  output logic               move_ready,
  output logic [N_CELLS-1:0] en,
  output logic               en_player,
  output logic               accept,
  output logic               reject,
  output logic [1:0]         reject_code,
  output logic               turn,
  output logic [N_CELLS-1:0] occupied,
  output logic [CNT_W-1:0]   move_count,
  output logic               board_full
);

  // state | meaning
  // IDLE  | ready for a move request
  // CHECK | captured index being validated, result pulses issued at the next edge
  // FULL  | every cell taken, requests ignored until rst/clr
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]         state;
  logic [SEL_W-1:0]   sel_q;
  logic [N_CELLS-1:0] sel_hot;
  logic               in_range;
  logic               occ_hit;
  logic [CNT_W-1:0]   count_inc;
  logic               last_move;

  // Decoding into a one-hot vector keeps out-of-range indices from ever producing a bit.
  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      sel_hot[i] = (sel_q == SEL_W'(i));
    end
  end

  assign in_range   = ({1'b0, sel_q} < (SEL_W + 1)'(N_CELLS));
  assign occ_hit    = |(occupied & sel_hot);
  assign count_inc  = move_count + CNT_W'(1);
  assign last_move  = (count_inc == CNT_W'(N_CELLS));
  assign move_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state       <= IDLE;
      en          <= '0;
      en_player   <= 1'b0;
      accept      <= 1'b0;
      reject      <= 1'b0;
      reject_code <= 2'b00;
      turn        <= 1'b0;
      occupied    <= '0;
      move_count  <= '0;
      board_full  <= 1'b0;
      if (rst) begin
        sel_q <= '0;
      end
    end else begin
      en          <= '0;
      en_player   <= 1'b0;
      accept      <= 1'b0;
      reject      <= 1'b0;
      reject_code <= 2'b00;
      case (state)
        IDLE: begin
          if (move_valid) begin
            sel_q <= move_sel;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!in_range) begin
            reject      <= 1'b1;
            reject_code <= 2'b10;
            state       <= IDLE;
          end else if (occ_hit) begin
            reject      <= 1'b1;
            reject_code <= 2'b01;
            state       <= IDLE;
          end else begin
            en         <= sel_hot;
            en_player  <= turn;
            accept     <= 1'b1;
            occupied   <= occupied | sel_hot;
            turn       <= ~turn;
            move_count <= count_inc;
            board_full <= last_move;
            state      <= last_move ? FULL : IDLE;
          end
        end
        FULL:    state <= FULL;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_select_decoder.sv
// Directed bench for move_select_decoder: a 9-cell instance and a 16-cell instance (CNT_W=5).
module tb_move_select_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        a_clr = 1'b0, a_valid = 1'b0;
  logic [3:0]  a_sel = '0;
  logic        a_ready, a_en_player, a_accept, a_reject, a_turn, a_full;
  logic [8:0]  a_en, a_occ;
  logic [1:0]  a_code;
  logic [3:0]  a_count;

  logic        b_clr = 1'b0, b_valid = 1'b0;
  logic [3:0]  b_sel = '0;
  logic        b_ready, b_en_player, b_accept, b_reject, b_turn, b_full;
  logic [15:0] b_en, b_occ;
  logic [1:0]  b_code;
  logic [4:0]  b_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  move_select_decoder #(.N_CELLS(9), .SEL_W(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .move_valid(a_valid), .move_sel(a_sel),
    .move_ready(a_ready), .en(a_en), .en_player(a_en_player), .accept(a_accept),
    .reject(a_reject), .reject_code(a_code), .turn(a_turn), .occupied(a_occ),
    .move_count(a_count), .board_full(a_full)
  );

  move_select_decoder #(.N_CELLS(16), .SEL_W(4), .CNT_W(5)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .move_valid(b_valid), .move_sel(b_sel),
    .move_ready(b_ready), .en(b_en), .en_player(b_en_player), .accept(b_accept),
    .reject(b_reject), .reject_code(b_code), .turn(b_turn), .occupied(b_occ),
    .move_count(b_count), .board_full(b_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on instance A and returns with outputs showing its result pulse.
  task automatic issue_a(input logic [3:0] sel);
    int k = 0;
    while (!a_ready && k < 20) begin
      tick();
      k++;
    end
    if (!a_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL a_ready_timeout got=%b want=1", a_ready);
    end
    a_valid = 1'b1;
    a_sel   = sel;
    tick();
    a_valid = 1'b0;
    a_sel   = 4'hf;
    tick();
  endtask

  task automatic issue_b(input logic [3:0] sel);
    int k = 0;
    while (!b_ready && k < 20) begin
      tick();
      k++;
    end
    if (!b_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL b_ready_timeout got=%b want=1", b_ready);
    end
    b_valid = 1'b1;
    b_sel   = sel;
    tick();
    b_valid = 1'b0;
    b_sel   = 4'h0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({a_en, a_en_player, a_accept, a_reject, a_code} !== 14'b0) begin
      n_bad++; $display("FAIL reset_pulses got=%h want=0", {a_en, a_en_player, a_accept, a_reject, a_code});
    end
    n_cmp++;
    if ({a_turn, a_occ, a_count, a_full} !== 15'b0) begin
      n_bad++; $display("FAIL reset_state got=%h want=0", {a_turn, a_occ, a_count, a_full});
    end
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready got=%b want=1", a_ready);
    end
  endtask

  task automatic test_accept();
    issue_a(4'd4);
    n_cmp++;
    if (a_en !== 9'b000010000 || a_en_player !== 1'b0 || a_accept !== 1'b1 || a_reject !== 1'b0) begin
      n_bad++; $display("FAIL accept_pulse got en=%b pl=%b acc=%b rej=%b want en=000010000 pl=0 acc=1 rej=0",
                        a_en, a_en_player, a_accept, a_reject);
    end
    n_cmp++;
    if (a_occ !== 9'h010 || a_turn !== 1'b1 || a_count !== 4'd1) begin
      n_bad++; $display("FAIL accept_state got occ=%h turn=%b cnt=%0d want occ=010 turn=1 cnt=1", a_occ, a_turn, a_count);
    end
    tick();
    n_cmp++;
    if (a_en !== 9'b0 || a_accept !== 1'b0) begin
      n_bad++; $display("FAIL accept_single_cycle got en=%b acc=%b want en=0 acc=0", a_en, a_accept);
    end
  endtask

  task automatic test_occupied();
    issue_a(4'd4);
    n_cmp++;
    if (a_reject !== 1'b1 || a_code !== 2'b01 || a_en !== 9'b0 || a_accept !== 1'b0) begin
      n_bad++; $display("FAIL occupied_reject got rej=%b code=%b en=%b acc=%b want rej=1 code=01 en=0 acc=0",
                        a_reject, a_code, a_en, a_accept);
    end
    n_cmp++;
    if (a_turn !== 1'b1 || a_count !== 4'd1) begin
      n_bad++; $display("FAIL occupied_state got turn=%b cnt=%0d want turn=1 cnt=1", a_turn, a_count);
    end
  endtask

  task automatic test_range();
    issue_a(4'd11);
    n_cmp++;
    if (a_reject !== 1'b1 || a_code !== 2'b10 || a_en !== 9'b0 || a_accept !== 1'b0) begin
      n_bad++; $display("FAIL range_reject got rej=%b code=%b en=%b acc=%b want rej=1 code=10 en=0 acc=0",
                        a_reject, a_code, a_en, a_accept);
    end
    n_cmp++;
    if (a_occ !== 9'h010 || a_turn !== 1'b1 || a_count !== 4'd1) begin
      n_bad++; $display("FAIL range_state got occ=%h turn=%b cnt=%0d want occ=010 turn=1 cnt=1", a_occ, a_turn, a_count);
    end
    tick();
    n_cmp++;
    if (a_reject !== 1'b0 || a_code !== 2'b00) begin
      n_bad++; $display("FAIL range_pulse_clear got rej=%b code=%b want rej=0 code=00", a_reject, a_code);
    end
  endtask

  // Back-to-back fill: each request lands at the edge the previous pulse is visible.
  task automatic test_back_to_back_fill();
    logic [8:0] exp_en;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_en = 9'b1 << i;
      issue_a(4'(i));
      n_cmp++;
      if (a_en !== exp_en || a_en_player !== 1'(i % 2) || a_accept !== 1'b1 ||
          a_count !== 4'(i + 1) || a_full !== (i == 8)) begin
        n_bad++; $display("FAIL fill_%0d got en=%b pl=%b acc=%b cnt=%0d full=%b want en=%b pl=%0d acc=1 cnt=%0d full=%0d",
                          i, a_en, a_en_player, a_accept, a_count, a_full, exp_en, i % 2, i + 1, i == 8);
      end
    end
    tick();
    n_cmp++;
    if (a_ready !== 1'b0 || a_full !== 1'b1 || a_occ !== 9'h1ff) begin
      n_bad++; $display("FAIL full_state got rdy=%b full=%b occ=%h want rdy=0 full=1 occ=1ff", a_ready, a_full, a_occ);
    end
    a_valid = 1'b1;
    a_sel   = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (a_en !== 9'b0 || a_accept !== 1'b0 || a_reject !== 1'b0 || a_count !== 4'd9) begin
        n_bad++; $display("FAIL full_ignore_%0d got en=%b acc=%b rej=%b cnt=%0d want en=0 acc=0 rej=0 cnt=9",
                          k, a_en, a_accept, a_reject, a_count);
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_clr_abort();
    do_reset();
    issue_a(4'd0);
    tick();
    a_valid = 1'b1;
    a_sel   = 4'd2;
    tick();
    a_valid = 1'b0;
    a_sel   = 4'd5;
    a_clr   = 1'b1;
    tick();
    a_clr = 1'b0;
    n_cmp++;
    if (a_en !== 9'b0 || a_accept !== 1'b0 || a_reject !== 1'b0) begin
      n_bad++; $display("FAIL clr_abort_pulses got en=%b acc=%b rej=%b want 0", a_en, a_accept, a_reject);
    end
    n_cmp++;
    if (a_occ !== 9'b0 || a_turn !== 1'b0 || a_count !== 4'd0 || a_ready !== 1'b1) begin
      n_bad++; $display("FAIL clr_state got occ=%h turn=%b cnt=%0d rdy=%b want occ=0 turn=0 cnt=0 rdy=1",
                        a_occ, a_turn, a_count, a_ready);
    end
    tick();
    n_cmp++;
    if (a_accept !== 1'b0 || a_en !== 9'b0) begin
      n_bad++; $display("FAIL clr_no_late_pulse got en=%b acc=%b want 0", a_en, a_accept);
    end
    issue_a(4'd2);
    n_cmp++;
    if (a_en !== 9'h004 || a_accept !== 1'b1 || a_en_player !== 1'b0) begin
      n_bad++; $display("FAIL clr_then_move got en=%h acc=%b pl=%b want en=004 acc=1 pl=0", a_en, a_accept, a_en_player);
    end
  endtask

  task automatic test_rst_clr_same();
    a_clr = 1'b1;
    rst   = 1'b1;
    tick();
    a_clr = 1'b0;
    rst   = 1'b0;
    n_cmp++;
    if (a_occ !== 9'b0 || a_count !== 4'd0 || a_turn !== 1'b0 || a_ready !== 1'b1 || a_en !== 9'b0) begin
      n_bad++; $display("FAIL rst_clr_same got occ=%h cnt=%0d turn=%b rdy=%b en=%h want 0 0 0 1 0",
                        a_occ, a_count, a_turn, a_ready, a_en);
    end
  endtask

  task automatic test_wide();
    do_reset();
    issue_b(4'd15);
    n_cmp++;
    if (b_en !== 16'h8000 || b_accept !== 1'b1 || b_en_player !== 1'b0 || b_count !== 5'd1) begin
      n_bad++; $display("FAIL wide_top_cell got en=%h acc=%b pl=%b cnt=%0d want en=8000 acc=1 pl=0 cnt=1",
                        b_en, b_accept, b_en_player, b_count);
    end
    for (int i = 0; i < 15; i++) begin
      issue_b(4'(i));
      if (i == 13) begin
        n_cmp++;
        if (b_full !== 1'b0 || b_count !== 5'd15) begin
          n_bad++; $display("FAIL wide_not_full got full=%b cnt=%0d want full=0 cnt=15", b_full, b_count);
        end
      end
    end
    n_cmp++;
    if (b_full !== 1'b1 || b_count !== 5'd16 || b_en !== 16'h4000 || b_occ !== 16'hffff) begin
      n_bad++; $display("FAIL wide_full got full=%b cnt=%0d en=%h occ=%h want full=1 cnt=16 en=4000 occ=ffff",
                        b_full, b_count, b_en, b_occ);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_occupied();
    test_range();
    test_back_to_back_fill();
    test_clr_abort();
    test_rst_clr_same();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
